// File: rtl/psd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// psd_ctrl_pkg
//   Shared definitions for the PSD accumulation sequencer.
//   - state_e  : sequencer state encoding (IDLE / ARM / ACCUM / HOLD)
//   - ADDR_LSB : byte-address shift applied to the sample counter
//                (accumulator words are 32 bits wide)
// ---------------------------------------------------------------------------
package psd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ACCUM = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int ADDR_LSB = 2;

endpackage

// File: rtl/psd_frame_counter.sv
// ---------------------------------------------------------------------------
// psd_frame_counter
//   Sample-within-frame counter (cnt) and averaging-cycle counter (cycle).
//   cnt advances on every accepted beat and wraps at PERIOD-1; the wrap
//   advances cycle, which itself wraps to 0 after cycle n_avg-1 so that a
//   continuous run starts the next bank from cnt=0, cycle=0 without help.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   clear_i         : force cnt=0, cycle=0 (held while not accumulating)
//   beat_i          : one accepted sample this cycle
//   n_avg_i         : averages per bank (already forced non-zero)
//   cnt_o           : current sample index within the frame
//   last_beat_o     : cnt == PERIOD-1
//   first_cycle_o   : cycle == 0
//   last_cycle_o    : cycle == n_avg-1
// ---------------------------------------------------------------------------
module psd_frame_counter
  import psd_ctrl_pkg::*;
#(
  parameter int PERIOD         = 256,
  parameter int PERIOD_WIDTH   = 8,
  parameter int N_CYCLES_WIDTH = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      beat_i,
  input  logic [N_CYCLES_WIDTH-1:0] n_avg_i,
  output logic [PERIOD_WIDTH-1:0]   cnt_o,
  output logic                      last_beat_o,
  output logic                      first_cycle_o,
  output logic                      last_cycle_o
);

  logic [PERIOD_WIDTH-1:0]   cnt_q,   cnt_d;
  logic [N_CYCLES_WIDTH-1:0] cycle_q, cycle_d;

  assign cnt_o         = cnt_q;
  assign last_beat_o   = (cnt_q == PERIOD_WIDTH'(PERIOD - 1));
  assign first_cycle_o = (cycle_q == '0);
  assign last_cycle_o  = (cycle_q == (n_avg_i - N_CYCLES_WIDTH'(1)));

  always_comb begin
    cnt_d   = cnt_q;
    cycle_d = cycle_q;
    if (clear_i) begin
      cnt_d   = '0;
      cycle_d = '0;
    end else if (beat_i) begin
      if (last_beat_o) begin
        cnt_d   = '0;
        cycle_d = last_cycle_o ? '0 : cycle_q + N_CYCLES_WIDTH'(1);
      end else begin
        cnt_d = cnt_q + PERIOD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      cycle_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      cycle_q <= cycle_d;
    end
  end

endmodule

// File: rtl/psd_acq_ctrl.sv
// ---------------------------------------------------------------------------
// psd_acq_ctrl
//   Sequencer between the FFT output stream and the PSD accumulator.
//   Aligns to an FFT frame boundary (tlast) after start, then counts samples
//   and averaging cycles, driving the accumulator address and first/last
//   cycle strobes. Completed banks ping-pong between two result buffers and
//   are handed to software with a done pulse and returned with rd_ack.
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   start / stop             : begin acquisition (IDLE only) / abort to IDLE
//   cfg_continuous           : re-arm automatically after every bank
//   cfg_n_avg                : averages per bank, 0 behaves as 1
//   rd_ack                   : software released bank rd_bank
//   s_axis_tvalid/tlast/tdata: FFT output stream
//   m_axis_tvalid/tdata      : beat forwarded to the accumulator (1 cycle)
//   addr                     : accumulator byte address {cnt, 2'b00}
//   first_cycle / last_cycle : beat belongs to cycle 0 / cycle n_avg-1
//   wr_bank / rd_bank        : bank being filled / last completed bank
//   busy, done, overrun      : status; overrun is sticky until next start
//   bank_count               : banks completed since start (wraps)
// ---------------------------------------------------------------------------
module psd_acq_ctrl
  import psd_ctrl_pkg::*;
#(
  parameter int PERIOD         = 256,
  parameter int PERIOD_WIDTH   = 8,
  parameter int N_CYCLES_WIDTH = 11
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             cfg_continuous,
  input  logic [N_CYCLES_WIDTH-1:0]        cfg_n_avg,
  input  logic                             rd_ack,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  input  logic [31:0]                      s_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic [31:0]                      m_axis_tdata,
  output logic [PERIOD_WIDTH+ADDR_LSB-1:0] addr,
  output logic                             first_cycle,
  output logic                             last_cycle,
  output logic                             wr_bank,
  output logic                             rd_bank,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun,
  output logic [31:0]                      bank_count
);

  function automatic logic [N_CYCLES_WIDTH-1:0] navg_sat(
    input logic [N_CYCLES_WIDTH-1:0] v
  );
    return (v == '0) ? N_CYCLES_WIDTH'(1) : v;
  endfunction

  state_e                    state_q, state_d;
  logic [N_CYCLES_WIDTH-1:0] n_avg_q, n_avg_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic                      bank_full_q, bank_full_d;
  logic                      overrun_q, overrun_d;
  logic [31:0]               bank_count_q, bank_count_d;
  logic                      done_q, done_d;

  logic [PERIOD_WIDTH-1:0]   cnt;
  logic                      last_beat, first_cyc, last_cyc;
  logic                      beat, bank_end, ack_eff, cnt_clear;

  // Only beats seen while accumulating move the counters or reach the
  // accumulator; ARM and HOLD discard the stream.
  assign beat      = s_axis_tvalid && (state_q == ST_ACCUM);
  assign bank_end  = beat && last_beat && last_cyc && !stop;
  assign ack_eff   = rd_ack && bank_full_q;
  assign cnt_clear = (state_q != ST_ACCUM);

  psd_frame_counter #(
    .PERIOD        (PERIOD),
    .PERIOD_WIDTH  (PERIOD_WIDTH),
    .N_CYCLES_WIDTH(N_CYCLES_WIDTH)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (cnt_clear),
    .beat_i       (beat),
    .n_avg_i      (n_avg_q),
    .cnt_o        (cnt),
    .last_beat_o  (last_beat),
    .first_cycle_o(first_cyc),
    .last_cycle_o (last_cyc)
  );

  always_comb begin
    state_d      = state_q;
    n_avg_d      = n_avg_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    overrun_d    = overrun_q;
    bank_count_d = bank_count_q;
    done_d       = 1'b0;

    // A release arriving together with a completion is applied first, so the
    // completion below may set bank_full again.
    if (ack_eff) begin
      bank_full_d = 1'b0;
    end

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d      = ST_ARM;
            n_avg_d      = navg_sat(cfg_n_avg);
            bank_count_d = '0;
            overrun_d    = 1'b0;
          end
        end
        ST_ARM: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            state_d = ST_ACCUM;
            n_avg_d = navg_sat(cfg_n_avg);
          end
        end
        ST_ACCUM: begin
          if (bank_end) begin
            done_d       = 1'b1;
            rd_bank_d    = wr_bank_q;
            bank_count_d = bank_count_q + 32'd1;
            bank_full_d  = 1'b1;
            if (!cfg_continuous) begin
              state_d = ST_IDLE;
            end else if (bank_full_q && !rd_ack) begin
              // The other bank is still with software: nowhere to write.
              state_d = ST_HOLD;
            end else begin
              wr_bank_d = ~wr_bank_q;
            end
          end
        end
        ST_HOLD: begin
          if (s_axis_tvalid) begin
            overrun_d = 1'b1;
          end
          if (ack_eff) begin
            wr_bank_d = ~wr_bank_q;
            state_d   = ST_ARM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_avg_q      <= N_CYCLES_WIDTH'(1);
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= 1'b0;
      overrun_q    <= 1'b0;
      bank_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_avg_q      <= n_avg_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      overrun_q    <= overrun_d;
      bank_count_q <= bank_count_d;
      done_q       <= done_d;
    end
  end

  // Stage p1: datapath outputs, one register after the input beat.
  logic                             vld_p1_q;
  logic [31:0]                      tdata_p1_q;
  logic [PERIOD_WIDTH+ADDR_LSB-1:0] addr_p1_q;
  logic                             first_p1_q;
  logic                             last_p1_q;
  logic                             wr_bank_p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      tdata_p1_q   <= '0;
      addr_p1_q    <= '0;
      first_p1_q   <= 1'b0;
      last_p1_q    <= 1'b0;
      wr_bank_p1_q <= 1'b0;
    end else begin
      vld_p1_q     <= beat;
      tdata_p1_q   <= s_axis_tdata;
      addr_p1_q    <= {cnt, {ADDR_LSB{1'b0}}};
      first_p1_q   <= beat && first_cyc;
      last_p1_q    <= beat && last_cyc;
      wr_bank_p1_q <= wr_bank_q;
    end
  end

  assign m_axis_tvalid = vld_p1_q;
  assign m_axis_tdata  = tdata_p1_q;
  assign addr          = addr_p1_q;
  assign first_cycle   = first_p1_q;
  assign last_cycle    = last_p1_q;
  assign wr_bank       = wr_bank_p1_q;
  assign rd_bank       = rd_bank_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign overrun       = overrun_q;
  assign bank_count    = bank_count_q;

endmodule
